canny_pixel_ops: RTL and testbench
==================================

# canny_pixel_ops

Per-pixel arithmetic core of the Canny edge pipeline: three independent, fully pipelined datapaths sharing one clock and reset. The Gaussian path smooths a 3x3 8-bit window. The gradient path applies Sobel kernels to a 3x3 window and produces magnitude and quantised direction. The threshold path classifies a post-NMS magnitude as none, weak or strong. Window assembly (line buffers), non-max suppression and hysteresis are external blocks.

## Interface
- LOW_THRESH, default 50: weak-edge threshold, 11-bit unsigned.
- HIGH_THRESH, default 100: strong-edge threshold, 11-bit unsigned, >= LOW_THRESH.
- clk  in  1  sole clock, rising edge.
- rstN  in  1  reset; one clock; reset is synchronous and active-high (asserted = 1, despite the codebase name).
- gaussian_data_in  in  72  3x3 window, element k at bits [8k+7:8k], k=0..8 row-major (k=0 top-left, k=4 centre).
- gaussian_data_in_valid  in  1  window valid.
- gaussian_pixel_out  out  8  smoothed pixel.
- gaussian_pixel_out_valid  out  1  result valid.
- gradient_data_in  in  72  3x3 window, same packing.
- gradient_data_in_valid  in  1  window valid.
- pixel_out_x / pixel_out_y  out  8 each  min(|Gx|,255) / min(|Gy|,255).
- pixel_xy_valid  out  1  x/y valid.
- gradient_magnitude  out  11  |Gx|+|Gy|.
- gradient_direction  out  2  0=0°, 1=45°, 2=90°, 3=135°.
- pixel_out  out  8  min(magnitude,255).
- gradient_out_valid  out  1  magnitude/direction/pixel_out valid.
- magnitude  in  11  post-NMS magnitude.
- mag_valid  in  1  magnitude valid.
- strength  out  2  0 none, 1 weak, 2 strong (3 never produced).
- str_valid  out  1  strength valid.

## Operation
- Gaussian: sum = p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8 (12-bit); out = sum>>4 (truncate, max 255, no saturation needed).
- Sobel: Gx = (p2+2p5+p8)-(p0+2p3+p6); Gy = (p6+2p7+p8)-(p0+2p1+p2); 11-bit signed, range ±1020.
- ax=|Gx|, ay=|Gy|; magnitude = ax+ay (max 2040, 11-bit unsigned).
- Direction: if 256·ay <= 106·ax -> 0; else if 256·ay >= 618·ax -> 2; else if sign(Gx)==sign(Gy) -> 1; else 3. Gx=Gy=0 gives 0. Products 20 bits wide, no overflow.
- Threshold: magnitude >= HIGH_THRESH -> 2; else >= LOW_THRESH -> 1; else 0.
- Paths share nothing but clk/rstN; no backpressure. Every valid input yields exactly one output, in order.
- Data outputs hold their last value when the matching valid is low.

## Timing
- Reset: all outputs and pipeline registers clear to 0, including all valids. Reset is sampled on clk and takes priority over input valid.
- Gaussian: latency 1 cycle (input at edge N, output valid after edge N+1).
- Gradient stage 1: registers Gx, Gy, pixel_out_x/y and pixel_xy_valid; latency 1.
- Gradient stage 2: registers magnitude, direction, pixel_out and gradient_out_valid; latency 2.
- Threshold: latency 1.
- Throughput: one result per path per cycle. Back-to-back valids produce back-to-back outputs.
- Valid gaps propagate unchanged.
- Reset mid-stream: in-flight data is discarded; the first output after reset comes from the first valid input presented after reset deasserts.

## Test plan
- Reset, then all windows = 100 -> gaussian 100; Gx=Gy=0, magnitude 0, direction 0, pixel_out 0. Outputs are 0 during reset.
- Vertical edge: left column 0, right 255, middle 0 -> Gx=1020, Gy=0, magnitude 1020, direction 0, pixel_out 255, x 255, y 0. Latencies are 1 (x/y) and 2 (magnitude).
- Window [0,10,20;10,20,30;20,30,40] -> gaussian 20, magnitude 160, direction 1. Window [20,10,0;30,20,10;40,30,20] -> magnitude 160, direction 3. Horizontal edge (top row 0, bottom row 255) -> direction 2.
- Impulse: centre 255, rest 0 -> gaussian 63 (truncation); Gx=Gy=0.
- Threshold sweep, defaults, back-to-back: magnitudes 0, 49, 50, 99, 100, 2040 -> strengths 0, 0, 1, 1, 2, 2, one per cycle. Then one idle cycle -> str_valid low for one cycle.
- Assert rstN for 1 cycle during a continuous stream -> all valids 0 the next cycle; the stream resumes with correct values for post-reset inputs only.

Source files
------------

// File: rtl/canny_pixel_ops.sv
// canny_pixel_ops: per-pixel datapaths of the Canny pipeline -- 3x3 Gaussian
// smoothing, Sobel gradient (magnitude + quantised direction) and double threshold.
module canny_pixel_ops #(
  parameter int unsigned LOW_THRESH  = 50,
  parameter int unsigned HIGH_THRESH = 100
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [71:0] gaussian_data_in,
  input  logic        gaussian_data_in_valid,
  output logic [7:0]  gaussian_pixel_out,
  output logic        gaussian_pixel_out_valid,
  input  logic [71:0] gradient_data_in,
  input  logic        gradient_data_in_valid,
  output logic [7:0]  pixel_out_x,
  output logic [7:0]  pixel_out_y,
  output logic        pixel_xy_valid,
  output logic [10:0] gradient_magnitude,
  output logic [1:0]  gradient_direction,
  output logic [7:0]  pixel_out,
  output logic        gradient_out_valid,
  input  logic [10:0] magnitude,
  input  logic        mag_valid,
  output logic [1:0]  strength,
  output logic        str_valid
);

  localparam int unsigned PW   = 8;   // pixel width
  localparam int unsigned WINW = 72;  // 3x3 window width
  localparam int unsigned MW   = 11;  // gradient / magnitude width
  localparam int unsigned SW   = 12;  // Gaussian accumulator width
  localparam int unsigned PRW  = 20;  // direction comparison product width

  function automatic logic [PW-1:0] px(input logic [WINW-1:0] w, input int unsigned k);
    return w[PW*k +: PW];
  endfunction

  // Weighted column/row sum a + 2b + c used by both Sobel kernels
  function automatic logic [MW-1:0] tri_sum(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic [PW-1:0] c);
    return MW'(a) + (MW'(b) << 1) + MW'(c);
  endfunction

  function automatic logic [MW-1:0] abs_val(input logic signed [MW-1:0] v);
    return v[MW-1] ? MW'(-v) : MW'(v);
  endfunction

  function automatic logic [PW-1:0] sat8(input logic [MW-1:0] v);
    return (v > MW'(255)) ? PW'(255) : v[PW-1:0];
  endfunction

  logic [SW-1:0]        gauss_sum;
  logic [PW-1:0]        gauss_pix_d, gauss_pix_q;
  logic                 gauss_vld_q;

  logic signed [MW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [PW-1:0]        px_x_d, px_y_d, px_x_q, px_y_q;
  logic                 xy_vld_q;

  logic [MW-1:0]        ax, ay;
  logic [PRW-1:0]       ay256, ax106, ax618;
  logic [MW-1:0]        mag_d, mag_q;
  logic [1:0]           dir_d, dir_q;
  logic [PW-1:0]        pix_d, pix_q;
  logic                 grad_vld_q;

  logic [1:0]           str_d, str_q;
  logic                 str_vld_q;

  // Gaussian: 1-2-1 / 2-4-2 / 1-2-1 kernel, normalised by 16 with truncation
  always_comb begin
    gauss_sum = SW'(px(gaussian_data_in, 0)) + (SW'(px(gaussian_data_in, 1)) << 1)
              + SW'(px(gaussian_data_in, 2)) + (SW'(px(gaussian_data_in, 3)) << 1)
              + (SW'(px(gaussian_data_in, 4)) << 2) + (SW'(px(gaussian_data_in, 5)) << 1)
              + SW'(px(gaussian_data_in, 6)) + (SW'(px(gaussian_data_in, 7)) << 1)
              + SW'(px(gaussian_data_in, 8));
    gauss_pix_d = PW'(gauss_sum >> 4);
  end

  // Sobel stage 1: signed gradients plus saturated absolute components
  always_comb begin
    gx_d = signed'(tri_sum(px(gradient_data_in, 2), px(gradient_data_in, 5), px(gradient_data_in, 8))
                 - tri_sum(px(gradient_data_in, 0), px(gradient_data_in, 3), px(gradient_data_in, 6)));
    gy_d = signed'(tri_sum(px(gradient_data_in, 6), px(gradient_data_in, 7), px(gradient_data_in, 8))
                 - tri_sum(px(gradient_data_in, 0), px(gradient_data_in, 1), px(gradient_data_in, 2)));
    px_x_d = sat8(abs_val(gx_d));
    px_y_d = sat8(abs_val(gy_d));
  end

  // Stage 2: L1 magnitude; direction bins split at tan(22.5)~106/256 and tan(67.5)~618/256
  always_comb begin
    ax    = abs_val(gx_q);
    ay    = abs_val(gy_q);
    mag_d = ax + ay;
    pix_d = sat8(mag_d);
    ay256 = PRW'(ay) << 8;
    ax106 = PRW'(ax) * PRW'(106);
    ax618 = PRW'(ax) * PRW'(618);
    dir_d = 2'd0;
    if (ay256 <= ax106) begin
      dir_d = 2'd0;
    end else if (ay256 >= ax618) begin
      dir_d = 2'd2;
    end else if (gx_q[MW-1] == gy_q[MW-1]) begin
      dir_d = 2'd1;
    end else begin
      dir_d = 2'd3;
    end
  end

  always_comb begin
    str_d = 2'd0;
    if (magnitude >= MW'(HIGH_THRESH)) begin
      str_d = 2'd2;
    end else if (magnitude >= MW'(LOW_THRESH)) begin
      str_d = 2'd1;
    end
  end

  // Valids follow their inputs every cycle; data registers only load on valid
  always_ff @(posedge clk) begin
    if (rstN) begin
      gauss_pix_q <= '0;
      gauss_vld_q <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      xy_vld_q    <= 1'b0;
      mag_q       <= '0;
      dir_q       <= '0;
      pix_q       <= '0;
      grad_vld_q  <= 1'b0;
      str_q       <= '0;
      str_vld_q   <= 1'b0;
    end else begin
      gauss_vld_q <= gaussian_data_in_valid;
      if (gaussian_data_in_valid) gauss_pix_q <= gauss_pix_d;
      xy_vld_q <= gradient_data_in_valid;
      if (gradient_data_in_valid) begin
        gx_q   <= gx_d;
        gy_q   <= gy_d;
        px_x_q <= px_x_d;
        px_y_q <= px_y_d;
      end
      grad_vld_q <= xy_vld_q;
      if (xy_vld_q) begin
        mag_q <= mag_d;
        dir_q <= dir_d;
        pix_q <= pix_d;
      end
      str_vld_q <= mag_valid;
      if (mag_valid) str_q <= str_d;
    end
  end

  assign gaussian_pixel_out       = gauss_pix_q;
  assign gaussian_pixel_out_valid = gauss_vld_q;
  assign pixel_out_x              = px_x_q;
  assign pixel_out_y              = px_y_q;
  assign pixel_xy_valid           = xy_vld_q;
  assign gradient_magnitude       = mag_q;
  assign gradient_direction       = dir_q;
  assign pixel_out                = pix_q;
  assign gradient_out_valid       = grad_vld_q;
  assign strength                 = str_q;
  assign str_valid                = str_vld_q;

endmodule

// File: tb/tb_canny_pixel_ops.sv
// Bench for canny_pixel_ops: directed windows/thresholds plus a randomized stream
// checked against a kernel-based reference model.
module tb_canny_pixel_ops;

  localparam int unsigned LOW  = 50;
  localparam int unsigned HIGH = 100;

  logic        clk = 1'b0;
  logic        rstN;
  logic [71:0] gaussian_data_in;
  logic        gaussian_data_in_valid;
  logic [7:0]  gaussian_pixel_out;
  logic        gaussian_pixel_out_valid;
  logic [71:0] gradient_data_in;
  logic        gradient_data_in_valid;
  logic [7:0]  pixel_out_x;
  logic [7:0]  pixel_out_y;
  logic        pixel_xy_valid;
  logic [10:0] gradient_magnitude;
  logic [1:0]  gradient_direction;
  logic [7:0]  pixel_out;
  logic        gradient_out_valid;
  logic [10:0] magnitude;
  logic        mag_valid;
  logic [1:0]  strength;
  logic        str_valid;

  canny_pixel_ops #(.LOW_THRESH(LOW), .HIGH_THRESH(HIGH)) dut (
    .clk(clk), .rstN(rstN),
    .gaussian_data_in(gaussian_data_in), .gaussian_data_in_valid(gaussian_data_in_valid),
    .gaussian_pixel_out(gaussian_pixel_out), .gaussian_pixel_out_valid(gaussian_pixel_out_valid),
    .gradient_data_in(gradient_data_in), .gradient_data_in_valid(gradient_data_in_valid),
    .pixel_out_x(pixel_out_x), .pixel_out_y(pixel_out_y), .pixel_xy_valid(pixel_xy_valid),
    .gradient_magnitude(gradient_magnitude), .gradient_direction(gradient_direction),
    .pixel_out(pixel_out), .gradient_out_valid(gradient_out_valid),
    .magnitude(magnitude), .mag_valid(mag_valid),
    .strength(strength), .str_valid(str_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int GK [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  int XK [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int YK [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  // Expected register contents after the next clock edge
  int e_g, e_gv, e_x, e_y, e_xyv, s1_gx, s1_gy, e_mag, e_dir, e_pix, e_gov, e_str, e_strv;

  function automatic int conv(input logic [71:0] w, input int k [9]);
    int s = 0;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] p;
      p = w[8*i +: 8];
      s += k[i] * int'({24'd0, p});
    end
    return s;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int dirf(input int gx, input int gy);
    int ax = iabs(gx);
    int ay = iabs(gy);
    if (256 * ay <= 106 * ax) return 0;
    if (256 * ay >= 618 * ax) return 2;
    return ((gx > 0) == (gy > 0)) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (rstN) begin
      e_g = 0; e_gv = 0; e_x = 0; e_y = 0; e_xyv = 0; s1_gx = 0; s1_gy = 0;
      e_mag = 0; e_dir = 0; e_pix = 0; e_gov = 0; e_str = 0; e_strv = 0;
    end else begin
      int m;
      m = int'({21'd0, magnitude});
      e_strv = int'(mag_valid);
      if (mag_valid) e_str = (m >= int'(HIGH)) ? 2 : (m >= int'(LOW)) ? 1 : 0;
      e_gov = e_xyv;
      if (e_xyv != 0) begin
        e_mag = iabs(s1_gx) + iabs(s1_gy);
        e_dir = dirf(s1_gx, s1_gy);
        e_pix = imin255(e_mag);
      end
      e_xyv = int'(gradient_data_in_valid);
      if (gradient_data_in_valid) begin
        s1_gx = conv(gradient_data_in, XK);
        s1_gy = conv(gradient_data_in, YK);
        e_x = imin255(iabs(s1_gx));
        e_y = imin255(iabs(s1_gy));
      end
      e_gv = int'(gaussian_data_in_valid);
      if (gaussian_data_in_valid) e_g = conv(gaussian_data_in, GK) / 16;
    end
  endtask

  task automatic check_all();
    chk("gauss_valid", 32'(gaussian_pixel_out_valid), e_gv);
    chk("gauss_pix", 32'(gaussian_pixel_out), e_g);
    chk("xy_valid", 32'(pixel_xy_valid), e_xyv);
    chk("pix_x", 32'(pixel_out_x), e_x);
    chk("pix_y", 32'(pixel_out_y), e_y);
    chk("grad_valid", 32'(gradient_out_valid), e_gov);
    chk("grad_mag", 32'(gradient_magnitude), e_mag);
    chk("grad_dir", 32'(gradient_direction), e_dir);
    chk("grad_pix", 32'(pixel_out), e_pix);
    chk("str_valid", 32'(str_valid), e_strv);
    chk("strength", 32'(strength), e_str);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_win(input int w [9], input logic vld);
    for (int i = 0; i < 9; i++) begin
      gaussian_data_in[8*i +: 8] = 8'(w[i]);
      gradient_data_in[8*i +: 8] = 8'(w[i]);
    end
    gaussian_data_in_valid = vld;
    gradient_data_in_valid = vld;
  endtask

  task automatic rand_win();
    logic edgy;
    edgy = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 9; i++) begin
      gaussian_data_in[8*i +: 8] = edgy ? ($urandom_range(0, 1) != 0 ? 8'hFF : 8'h00) : 8'($urandom);
      gradient_data_in[8*i +: 8] = edgy ? ($urandom_range(0, 1) != 0 ? 8'hFF : 8'h00) : 8'($urandom);
    end
  endtask

  int w [9];
  int thr_mag [6] = '{0, 49, 50, 99, 100, 2040};
  int thr_str [6] = '{0, 0, 1, 1, 2, 2};

  initial begin
    rstN = 1'b1;
    gaussian_data_in = '0; gaussian_data_in_valid = 1'b0;
    gradient_data_in = '0; gradient_data_in_valid = 1'b0;
    magnitude = '0; mag_valid = 1'b0;

    // Reset with valid inputs present: outputs must stay at zero
    w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    set_win(w, 1'b1);
    mag_valid = 1'b1; magnitude = 11'd500;
    step();
    chk("rst_gauss_valid", 32'(gaussian_pixel_out_valid), 0);
    chk("rst_str_valid", 32'(str_valid), 0);
    step();
    rstN = 1'b0;
    mag_valid = 1'b0;

    // Directed windows, back to back
    step();
    chk("flat_gauss", 32'(gaussian_pixel_out), 100);
    chk("flat_x", 32'(pixel_out_x), 0);
    w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    set_win(w, 1'b1);
    step();
    chk("vedge_x", 32'(pixel_out_x), 255);
    chk("vedge_y", 32'(pixel_out_y), 0);
    chk("flat_mag", 32'(gradient_magnitude), 0);
    chk("flat_dir", 32'(gradient_direction), 0);
    w = '{0, 10, 20, 10, 20, 30, 20, 30, 40};
    set_win(w, 1'b1);
    step();
    chk("diag1_gauss", 32'(gaussian_pixel_out), 20);
    chk("vedge_mag", 32'(gradient_magnitude), 1020);
    chk("vedge_dir", 32'(gradient_direction), 0);
    chk("vedge_pix", 32'(pixel_out), 255);
    w = '{20, 10, 0, 30, 20, 10, 40, 30, 20};
    set_win(w, 1'b1);
    step();
    chk("diag1_mag", 32'(gradient_magnitude), 160);
    chk("diag1_dir", 32'(gradient_direction), 1);
    w = '{0, 0, 0, 0, 0, 0, 255, 255, 255};
    set_win(w, 1'b1);
    step();
    chk("diag2_mag", 32'(gradient_magnitude), 160);
    chk("diag2_dir", 32'(gradient_direction), 3);
    w = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
    set_win(w, 1'b1);
    step();
    chk("impulse_gauss", 32'(gaussian_pixel_out), 63);
    chk("hedge_mag", 32'(gradient_magnitude), 1020);
    chk("hedge_dir", 32'(gradient_direction), 2);
    set_win(w, 1'b0);
    step();
    chk("idle_gauss_valid", 32'(gaussian_pixel_out_valid), 0);
    chk("impulse_mag", 32'(gradient_magnitude), 0);
    step();
    chk("idle_grad_valid", 32'(gradient_out_valid), 0);

    // Threshold sweep, one per cycle, then a gap
    for (int i = 0; i < 6; i++) begin
      magnitude = 11'(thr_mag[i]);
      mag_valid = 1'b1;
      step();
      chk($sformatf("thr_%0d", thr_mag[i]), 32'(strength), thr_str[i]);
      chk("thr_valid", 32'(str_valid), 1);
    end
    mag_valid = 1'b0;
    magnitude = 11'd0;
    step();
    chk("thr_gap_valid", 32'(str_valid), 0);
    chk("thr_gap_hold", 32'(strength), 2);

    // One-cycle reset in the middle of a continuous stream
    for (int i = 0; i < 7; i++) begin
      rand_win();
      gaussian_data_in_valid = 1'b1;
      gradient_data_in_valid = 1'b1;
      magnitude = 11'($urandom_range(0, 2047));
      mag_valid = 1'b1;
      rstN = (i == 3);
      step();
      if (i == 3) begin
        chk("mid_rst_gv", 32'(gaussian_pixel_out_valid), 0);
        chk("mid_rst_xyv", 32'(pixel_xy_valid), 0);
        chk("mid_rst_gov", 32'(gradient_out_valid), 0);
        chk("mid_rst_strv", 32'(str_valid), 0);
      end
      if (i == 4) chk("post_rst_gov", 32'(gradient_out_valid), 0);
      if (i == 5) chk("post_rst_gov2", 32'(gradient_out_valid), 1);
    end
    rstN = 1'b0;

    // Randomized stream with sporadic valid gaps and resets
    for (int i = 0; i < 600; i++) begin
      rand_win();
      gaussian_data_in_valid = ($urandom_range(0, 3) != 0);
      gradient_data_in_valid = ($urandom_range(0, 3) != 0);
      magnitude = 11'($urandom_range(0, 2047));
      mag_valid = ($urandom_range(0, 3) != 0);
      rstN = ($urandom_range(0, 59) == 0);
      step();
    end
    rstN = 1'b0;
    gaussian_data_in_valid = 1'b0;
    gradient_data_in_valid = 1'b0;
    mag_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
